// File: rtl/sha256_msg_loader.sv
// ---------------------------------------------------------------------------
// sha256_msg_loader
//
// Front end for a fixed-length SHA256 core. Collects a MSG_BYTES-byte
// message from a valid/ready byte stream, packs it MSB-first (first byte in
// the top byte of core_message), fires a one-cycle start pulse to the core,
// captures the core's one-cycle digest and holds it until the consumer takes
// it. Malformed message lengths and a hung core raise a one-cycle err pulse.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   s_valid/s_data/s_last/s_ready   byte stream in (valid/ready)
//   core_valid_in   start pulse to the core
//   core_message    packed message held for the core
//   core_valid_out  core done pulse, core_hash digest valid with it
//   m_valid/m_hash/m_ready          held digest out (valid/ready)
//   err             one-cycle error pulse (bad length or core timeout)
// ---------------------------------------------------------------------------
module sha256_msg_loader #(
    parameter int MSG_BYTES = 55,
    parameter int TIMEOUT   = 100
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    input  logic [7:0]             s_data,
    input  logic                   s_last,
    output logic                   s_ready,
    output logic                   core_valid_in,
    output logic [MSG_BYTES*8-1:0] core_message,
    input  logic                   core_valid_out,
    input  logic [255:0]           core_hash,
    output logic                   m_valid,
    output logic [255:0]           m_hash,
    input  logic                   m_ready,
    output logic                   err
);

    localparam int          MSG_W       = MSG_BYTES * 8;
    localparam logic [5:0]  LAST_IDX    = 6'(MSG_BYTES - 1);
    localparam logic [6:0]  TIMEOUT_VAL = 7'(TIMEOUT);
    // The TIMEOUT-th WAIT cycle is the one whose counter reads TIMEOUT-1.
    localparam logic [6:0]  TIMEOUT_M1  = 7'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [5:0]         byte_cnt_r;
    logic [5:0]         byte_cnt_s;
    logic [MSG_W-1:0]   msg_r;
    logic [MSG_W-1:0]   msg_s;
    logic [6:0]         timer_r;
    logic [6:0]         timer_s;
    logic [255:0]       m_hash_r;
    logic [255:0]       m_hash_s;
    logic               err_r;
    logic               err_s;
    logic               xfer_s;

    // Moore outputs decoded from the state register; s_ready is also held
    // low while reset is asserted so no byte is ever taken during reset.
    assign s_ready       = rst_n & ((state_r == ST_LOAD) | (state_r == ST_DRAIN));
    assign core_valid_in = (state_r == ST_START);
    assign m_valid       = (state_r == ST_HOLD);
    assign core_message  = msg_r;
    assign m_hash        = m_hash_r;
    assign err           = err_r;
    assign xfer_s        = s_valid & s_ready;

    // Next-state, datapath update and error decode.
    always_comb begin
        state_s    = state_r;
        byte_cnt_s = byte_cnt_r;
        msg_s      = msg_r;
        timer_s    = timer_r;
        m_hash_s   = m_hash_r;
        err_s      = 1'b0;

        case (state_r)
            ST_LOAD: begin
                if (xfer_s) begin
                    msg_s = {msg_r[MSG_W-9:0], s_data};
                    if (byte_cnt_r == LAST_IDX) begin
                        byte_cnt_s = 6'd0;
                        if (s_last) begin
                            state_s = ST_START;
                        end else begin
                            // Too long: flag now and swallow the remainder.
                            err_s   = 1'b1;
                            state_s = ST_DRAIN;
                        end
                    end else if (s_last) begin
                        // Too short: flag and restart collection in place.
                        err_s      = 1'b1;
                        byte_cnt_s = 6'd0;
                    end else begin
                        byte_cnt_s = byte_cnt_r + 6'd1;
                    end
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_START: begin
                timer_s = 7'd0;
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (timer_r == TIMEOUT_VAL) begin
                    timer_s = timer_r;
                end else begin
                    timer_s = timer_r + 7'd1;
                end
                // Done has priority over a coincident timeout.
                if (core_valid_out) begin
                    m_hash_s = core_hash;
                    state_s  = ST_HOLD;
                end else if (timer_r >= TIMEOUT_M1) begin
                    err_s   = 1'b1;
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (m_ready) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                if (xfer_s && s_last) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s    = ST_LOAD;
                byte_cnt_s = 6'd0;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_LOAD;
            byte_cnt_r <= 6'd0;
            msg_r      <= '0;
            timer_r    <= 7'd0;
            m_hash_r   <= 256'd0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            byte_cnt_r <= byte_cnt_s;
            msg_r      <= msg_s;
            timer_r    <= timer_s;
            m_hash_r   <= m_hash_s;
            err_r      <= err_s;
        end
    end

endmodule

// File: tb/tb_sha256_msg_loader.sv
// ---------------------------------------------------------------------------
// tb_sha256_msg_loader
//
// Self-checking bench for sha256_msg_loader. A mock core answers start
// pulses after a chosen delay; expectations come from message-length rules
// (exactly MSG_BYTES -> start, shorter -> err at the last byte, longer ->
// err at byte MSG_BYTES then drain) and from MSB-first byte packing.
// ---------------------------------------------------------------------------
module tb_sha256_msg_loader;

    localparam int MSG_BYTES = 55;
    localparam int TIMEOUT   = 100;
    localparam logic [255:0] HASH_CONST =
        256'h0123456789abcdef0123456789abcdef0123456789abcdef0123456789abcdef;

    logic           clk;
    logic           rst_n;
    logic           s_valid;
    logic [7:0]     s_data;
    logic           s_last;
    logic           s_ready;
    logic           core_valid_in;
    logic [439:0]   core_message;
    logic           core_valid_out;
    logic [255:0]   core_hash;
    logic           m_valid;
    logic [255:0]   m_hash;
    logic           m_ready;
    logic           err;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int start_cnt    = 0;
    int start_cyc    = -1;
    int err_cnt      = 0;
    int err_cyc      = -1;
    logic [255:0] last_hash = 256'd0;

    sha256_msg_loader #(
        .MSG_BYTES (MSG_BYTES),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_valid        (s_valid),
        .s_data         (s_data),
        .s_last         (s_last),
        .s_ready        (s_ready),
        .core_valid_in  (core_valid_in),
        .core_message   (core_message),
        .core_valid_out (core_valid_out),
        .core_hash      (core_hash),
        .m_valid        (m_valid),
        .m_hash         (m_hash),
        .m_ready        (m_ready),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter plus start/err pulse bookkeeping, sampled mid-cycle.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (core_valid_in === 1'b1) begin
            start_cnt = start_cnt + 1;
            start_cyc = cyc;
        end
        if (err === 1'b1) begin
            err_cnt = err_cnt + 1;
            err_cyc = cyc;
        end
    end

    task automatic check_eq(input string tag, input logic [439:0] got, input logic [439:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sample;
        @(negedge clk);
        #1;
    endtask

    // Offers one byte after a random idle gap; returns the cycle stamp of
    // the accepting edge and how many offered cycles were refused.
    task automatic send_byte(input logic [7:0] d, input bit last, input int gap_max,
                             output int xc, output int stalls);
        bit rdy;
        bit done;
        stalls = 0;
        xc     = 0;
        done   = 1'b0;
        s_valid = 1'b0;
        repeat ($urandom_range(gap_max)) begin
            @(posedge clk);
            #1;
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            rdy = s_ready;
            @(posedge clk);
            xc = cyc;
            if (rdy) done = 1'b1;
            else     stalls++;
            #1;
        end
        if (!done) check_eq("xfer_timeout", 440'd0, 440'd1);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_msg(input int len, input int gap_max, input bit ramp,
                            output logic [439:0] exp_msg, output int last_xc, output int err_xc);
        logic [7:0] b;
        int xc;
        int st;
        int stalls;
        int err_idx;
        stalls  = 0;
        exp_msg = '0;
        err_xc  = -1;
        last_xc = -1;
        err_idx = (len < MSG_BYTES) ? len - 1 : MSG_BYTES - 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < len; i++) begin
            b = ramp ? 8'(i) : 8'($urandom);
            if (i < MSG_BYTES) exp_msg[439 - 8*i -: 8] = b;
            send_byte(b, (i == len - 1), gap_max, xc, st);
            stalls += st;
            if (len != MSG_BYTES && i == err_idx) err_xc = xc;
            last_xc = xc;
        end
        check_eq("no_stall", 440'(stalls), 440'd0);
    endtask

    // Good message: start timing/packing, mock core done, held digest.
    task automatic run_good(input int gap, input int delay, input int hold,
                            input bit ramp, input logic [255:0] h);
        logic [439:0] exp_msg;
        int lx;
        int ex;
        int e0;
        int s0;
        e0 = err_cnt;
        s0 = start_cnt;
        send_msg(MSG_BYTES, gap, ramp, exp_msg, lx, ex);
        sample();
        check_eq("start_pulse", 440'(core_valid_in), 440'd1);
        check_eq("start_time", 440'(start_cyc), 440'(lx + 1));
        check_eq("core_message", core_message, exp_msg);
        sample();
        check_eq("start_one_cycle", 440'(core_valid_in), 440'd0);
        repeat (delay) @(posedge clk);
        #1;
        core_valid_out = 1'b1;
        core_hash      = h;
        @(posedge clk);
        #1;
        core_valid_out = 1'b0;
        core_hash      = {8{$urandom}};
        sample();
        check_eq("m_valid_rise", 440'(m_valid), 440'd1);
        check_eq("m_hash", 440'(m_hash), 440'(h));
        check_eq("msg_stable_wait", core_message, exp_msg);
        for (int k = 0; k < hold; k++) begin
            sample();
            check_eq("m_valid_hold", 440'(m_valid), 440'd1);
            check_eq("m_hash_hold", 440'(m_hash), 440'(h));
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        sample();
        check_eq("m_valid_at_ready", 440'(m_valid), 440'd1);
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        sample();
        check_eq("m_valid_drop", 440'(m_valid), 440'd0);
        last_hash = h;
        // A stray done pulse outside WAIT must not disturb the held digest.
        @(posedge clk);
        #1;
        core_valid_out = 1'b1;
        @(posedge clk);
        #1;
        core_valid_out = 1'b0;
        sample();
        check_eq("stray_done_hash", 440'(m_hash), 440'(h));
        check_eq("stray_done_valid", 440'(m_valid), 440'd0);
        check_eq("good_no_err", 440'(err_cnt - e0), 440'd0);
        check_eq("good_one_start", 440'(start_cnt - s0), 440'd1);
    endtask

    // Wrong length: one err pulse right after the offending byte, no start.
    task automatic run_bad(input int len, input int gap);
        logic [439:0] exp_msg;
        int lx;
        int ex;
        int e0;
        int s0;
        e0 = err_cnt;
        s0 = start_cnt;
        send_msg(len, gap, 1'b0, exp_msg, lx, ex);
        repeat (3) sample();
        check_eq("bad_err_count", 440'(err_cnt - e0), 440'd1);
        check_eq("bad_err_time", 440'(err_cyc), 440'(ex + 1));
        check_eq("bad_no_start", 440'(start_cnt - s0), 440'd0);
        check_eq("bad_ready_after", 440'(s_ready), 440'd1);
    endtask

    task automatic run_timeout;
        logic [439:0] exp_msg;
        int lx;
        int ex;
        int e0;
        e0 = err_cnt;
        send_msg(MSG_BYTES, 0, 1'b0, exp_msg, lx, ex);
        sample();
        check_eq("to_start", 440'(core_valid_in), 440'd1);
        for (int k = 0; k < TIMEOUT + 20 && err_cnt == e0; k++) sample();
        check_eq("to_err_count", 440'(err_cnt - e0), 440'd1);
        // START is one cycle, WAIT entered the cycle after it.
        check_eq("to_err_time", 440'(err_cyc - start_cyc), 440'(TIMEOUT + 1));
        check_eq("to_m_valid", 440'(m_valid), 440'd0);
        check_eq("to_ready", 440'(s_ready), 440'd1);
        check_eq("to_hash_kept", 440'(m_hash), 440'(last_hash));
        sample();
        check_eq("to_err_single", 440'(err), 440'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_s_ready"}, 440'(s_ready), 440'd0);
        check_eq({tag, "_start"}, 440'(core_valid_in), 440'd0);
        check_eq({tag, "_message"}, core_message, 440'd0);
        check_eq({tag, "_m_valid"}, 440'(m_valid), 440'd0);
        check_eq({tag, "_m_hash"}, 440'(m_hash), 440'd0);
        check_eq({tag, "_err"}, 440'(err), 440'd0);
    endtask

    initial begin
        logic [439:0] msg_tmp;
        int lx;
        int ex;
        int kind;
        rst_n          = 1'b0;
        s_valid        = 1'b0;
        s_data         = 8'd0;
        s_last         = 1'b0;
        core_valid_out = 1'b0;
        core_hash      = 256'd0;
        m_ready        = 1'b0;
        #1;
        check_reset_outputs("reset");
        #22;
        rst_n = 1'b1;
        #1;
        check_eq("ready_after_reset", 440'(s_ready), 440'd1);

        run_good(0, 66, 10, 1'b1, HASH_CONST);
        run_bad(10, 0);
        run_good(1, $urandom_range(80, 1), 2, 1'b0, {8{$urandom}});
        run_bad(60, 0);
        run_good(0, $urandom_range(80, 1), 1, 1'b0, {8{$urandom}});
        run_timeout();
        // Done arriving in the very cycle the timeout would fire.
        run_good(0, TIMEOUT - 1, 0, 1'b0, {8{$urandom}});

        for (int it = 0; it < 12; it++) begin
            kind = $urandom_range(3);
            case (kind)
                0, 1:    run_good($urandom_range(2), $urandom_range(80, 1),
                                  $urandom_range(4), 1'b0, {8{$urandom}});
                2:       run_bad($urandom_range(MSG_BYTES - 1, 1), $urandom_range(2));
                default: run_bad($urandom_range(70, MSG_BYTES + 1), $urandom_range(2));
            endcase
        end

        // Reset in the middle of WAIT drops everything back to reset values.
        send_msg(MSG_BYTES, 0, 1'b0, msg_tmp, lx, ex);
        repeat (10) sample();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check_eq("mid_reset_ready", 440'(s_ready), 440'd1);
        run_good(0, $urandom_range(80, 1), 0, 1'b0, {8{$urandom}});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
